operand_collector: RTL and testbench
====================================

OPERAND_COLLECTOR -- requirements
Module: operand_collector

Interface
REQ-001 SHALL have ports clk (input, 1, sole clock) and resetn (input, 1); one clock; reset is asynchronous and active-low.
REQ-002 SHALL have in_valid (input, 1), in_ready (output, 1), in_rs/in_rt/in_dest (input, 5 each), in_use_rs/in_use_rt (input, 1 each), in_pc (input, 32): decoded-instruction handshake from ID.
REQ-003 SHALL have rf_raddr1/rf_raddr2 (output, 5), rf_rdata1/rf_rdata2 (input, 32), rf_rdata1_valid/rf_rdata2_valid (input, 1): combinational read side of the scoreboarded register file.
REQ-004 SHALL have id_dest (output, 5): destination marked not-ready in the register file; zero means no marking.
REQ-005 SHALL have out_valid (output, 1), out_ready (input, 1), out_rs_data/out_rt_data (output, 32), out_dest (output, 5), out_pc (output, 32): issue handshake to EXE.
REQ-006 SHALL have flush (input, 1), stall_cycles (output, 8) and timeout (output, 1).

Function
REQ-007 SHALL implement FSM states IDLE, WAIT, HOLD.
REQ-008 IDLE: in_ready=1; in_valid&in_ready latches rs, rt, use flags, dest, pc; next state WAIT.
REQ-009 WAIT: in_ready=0; rf_raddr1=latched rs, rf_raddr2=latched rt; in other states raddr outputs hold their last value.
REQ-010 An operand SHALL count as ready if its use flag is 0, its address is 0, or its rf valid bit is 1.
REQ-011 WAIT with both operands ready SHALL, at that clock edge, capture rdata (forced 0 for address 0) into out_*_data, load out_dest/out_pc, set out_valid, and go to HOLD.
REQ-012 id_dest SHALL equal latched dest for exactly the cycle following the WAIT->HOLD edge, and 0 otherwise.
REQ-013 Minimum latency: operands ready on entry -> accept edge N, out_valid high after edge N+1.
REQ-014 HOLD: out_valid=1 and outputs stable until out_valid&out_ready; in_ready=out_ready.
REQ-015 HOLD with out_ready and in_valid in the same cycle SHALL retire and accept in that one cycle, next state WAIT; out_ready alone -> IDLE.
REQ-016 stall_cycles SHALL clear on every WAIT entry, increment per WAIT cycle with an operand not ready, saturate at 255, and hold its value outside WAIT.
REQ-017 flush=1 SHALL force IDLE at the next edge from any state: out_valid=0, id_dest=0, latched instruction dropped, stall_cycles cleared; flush wins over a simultaneous accept or retire.

Reset
REQ-018 resetn low SHALL asynchronously set state IDLE and clear all registered outputs and latched fields to 0 (in_ready=1 after reset).
REQ-019 Reset mid-WAIT or mid-HOLD SHALL discard the instruction with no id_dest pulse.

Configuration
REQ-020 Macro OPCOL_WATCHDOG_EN defined: stall_cycles reaching 255 in WAIT SHALL pulse timeout for one cycle and force IDLE, dropping the instruction without an id_dest pulse.
REQ-021 Macro OPCOL_WATCHDOG_EN undefined: timeout SHALL be tied to 0 and WAIT SHALL persist indefinitely.

Structure
REQ-022 The state encoding (IDLE=2'd0, WAIT=2'd1, HOLD=2'd2), STALL_MAX=8'd255 and the register-address width SHALL live in the shared package opcol_pkg.
REQ-023 Stall counting and the watchdog SHALL be the single sub-module opcol_stall_timer; everything else stays flat.

Verification
REQ-024 rs=3, rt=4, both valid, data 0x11/0x22, out_ready=1 -> out_valid two edges after accept, data 0x11/0x22, one-cycle id_dest=dest, stall_cycles=0.
REQ-025 rs=5 invalid for 6 cycles, then valid with 0xDEAD -> stall_cycles=6, out_rs_data=0xDEAD, id_dest pulses once.
REQ-026 rs=0 with use_rs=1 and rf valid bit 0 -> no stall, out_rs_data=0.
REQ-027 HOLD with out_ready=0 for 3 cycles, then out_ready and in_valid together -> outputs stable for 3 cycles, back-to-back accept, state WAIT.
REQ-028 flush asserted in WAIT and again in HOLD concurrent with in_valid -> IDLE next edge, out_valid=0, no id_dest pulse, new instruction not accepted.
REQ-029 OPCOL_WATCHDOG_EN defined, rt never valid -> timeout pulse at stall_cycles=255, then IDLE; undefined -> timeout stays 0, stall_cycles holds 255.

Source files
------------

// File: rtl/operand_collector_pkg.sv
// Shared types and constants for the operand collector: FSM encoding,
// register-address width and the stall saturation limit.
package opcol_pkg;

  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [7:0] STALL_MAX = 8'd255;

endpackage

// File: rtl/operand_collector_if.sv
// ID-side and EXE-side handshakes of the operand collector.
// slave is the collector's view; master is the environment's view.
interface operand_collector_if;
  import opcol_pkg::*;

  logic        in_valid;
  logic        in_ready;
  reg_addr_t   in_rs;
  reg_addr_t   in_rt;
  reg_addr_t   in_dest;
  logic        in_use_rs;
  logic        in_use_rt;
  logic [31:0] in_pc;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rs_data;
  logic [31:0] out_rt_data;
  reg_addr_t   out_dest;
  logic [31:0] out_pc;

  modport slave (
    input  in_valid, in_rs, in_rt, in_dest, in_use_rs, in_use_rt, in_pc, out_ready,
    output in_ready, out_valid, out_rs_data, out_rt_data, out_dest, out_pc
  );

  modport master (
    output in_valid, in_rs, in_rt, in_dest, in_use_rs, in_use_rt, in_pc, out_ready,
    input  in_ready, out_valid, out_rs_data, out_rt_data, out_dest, out_pc
  );

endinterface

// File: rtl/operand_collector_stall_timer.sv
// Per-instruction stall counter for the WAIT state, saturating at STALL_MAX.
// With OPCOL_WATCHDOG_EN defined, a saturated stall trips a one-cycle timeout.
module opcol_stall_timer
  import opcol_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       count_en,
  output logic [7:0] stall_cycles,
  output logic       trip,
  output logic       timeout
);

  logic [7:0] count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= 8'd0;
    end else if (clear) begin
      count_q <= 8'd0;
    end else if (count_en && (count_q != STALL_MAX)) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign stall_cycles = count_q;

`ifdef OPCOL_WATCHDOG_EN
  logic timeout_q;

  // Trip only while still stalled at the limit; an operand arriving wins.
  assign trip = count_en && (count_q == STALL_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= trip && !clear;
    end
  end

  assign timeout = timeout_q;
`else
  assign trip    = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/operand_collector.sv
// Operand collector: latches a decoded instruction, waits on the register-file
// scoreboard, then issues to EXE. Watchdog build option: OPCOL_WATCHDOG_EN.
module operand_collector
  import opcol_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  operand_collector_if.slave  bus,
  output reg_addr_t           rf_raddr1,
  output reg_addr_t           rf_raddr2,
  input  logic [31:0]         rf_rdata1,
  input  logic [31:0]         rf_rdata2,
  input  logic                rf_rdata1_valid,
  input  logic                rf_rdata2_valid,
  output reg_addr_t           id_dest,
  input  logic                flush,
  output logic [7:0]          stall_cycles,
  output logic                timeout
);

  state_t      state_q, state_d;
  reg_addr_t   rs_q, rt_q, dest_q;
  logic        use_rs_q, use_rt_q;
  logic [31:0] pc_q;
  reg_addr_t   raddr1_q, raddr2_q;

  logic        out_valid_q;
  logic [31:0] out_rs_q, out_rt_q, out_pc_q;
  reg_addr_t   out_dest_q, id_dest_q;

  logic rs_rdy, rt_rdy, ops_rdy;
  logic in_ready_c, accept, retire, issue;
  logic stall_en, stall_clear, wd_trip;

  assign rs_rdy  = !use_rs_q || (rs_q == '0) || rf_rdata1_valid;
  assign rt_rdy  = !use_rt_q || (rt_q == '0) || rf_rdata2_valid;
  assign ops_rdy = rs_rdy && rt_rdy;

  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    accept     = 1'b0;
    retire     = 1'b0;
    issue      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ops_rdy) begin
          issue   = 1'b1;
          state_d = HOLD;
        end else if (wd_trip) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        in_ready_c = bus.out_ready;
        if (bus.out_ready) begin
          retire = 1'b1;
          if (bus.in_valid) begin
            accept  = 1'b1;
            state_d = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush overrides everything, including advertising ready to ID.
    if (flush) begin
      state_d    = IDLE;
      in_ready_c = 1'b0;
      accept     = 1'b0;
      retire     = 1'b0;
      issue      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn || flush) begin
      rs_q     <= '0;
      rt_q     <= '0;
      dest_q   <= '0;
      use_rs_q <= 1'b0;
      use_rt_q <= 1'b0;
      pc_q     <= 32'd0;
    end else if (accept) begin
      rs_q     <= bus.in_rs;
      rt_q     <= bus.in_rt;
      dest_q   <= bus.in_dest;
      use_rs_q <= bus.in_use_rs;
      use_rt_q <= bus.in_use_rt;
      pc_q     <= bus.in_pc;
    end
  end

  // Read addresses track the latched operands in WAIT and freeze elsewhere,
  // so dropping the latched instruction never disturbs the RF read port.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      raddr1_q <= '0;
      raddr2_q <= '0;
    end else if (state_q == WAIT) begin
      raddr1_q <= rs_q;
      raddr2_q <= rt_q;
    end
  end

  assign rf_raddr1 = (state_q == WAIT) ? rs_q : raddr1_q;
  assign rf_raddr2 = (state_q == WAIT) ? rt_q : raddr2_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_rs_q    <= 32'd0;
      out_rt_q    <= 32'd0;
      out_dest_q  <= '0;
      out_pc_q    <= 32'd0;
      id_dest_q   <= '0;
    end else begin
      id_dest_q <= issue ? dest_q : '0;
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (issue) begin
        out_valid_q <= 1'b1;
        out_rs_q    <= (rs_q == '0) ? 32'd0 : rf_rdata1;
        out_rt_q    <= (rt_q == '0) ? 32'd0 : rf_rdata2;
        out_dest_q  <= dest_q;
        out_pc_q    <= pc_q;
      end else if (retire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_rs_data = out_rs_q;
  assign bus.out_rt_data = out_rt_q;
  assign bus.out_dest    = out_dest_q;
  assign bus.out_pc      = out_pc_q;
  assign id_dest         = id_dest_q;

  assign stall_en    = (state_q == WAIT) && !ops_rdy;
  assign stall_clear = flush || accept;

  opcol_stall_timer u_stall_timer (
    .clk          (clk),
    .resetn       (resetn),
    .clear        (stall_clear),
    .count_en     (stall_en),
    .stall_cycles (stall_cycles),
    .trip         (wd_trip),
    .timeout      (timeout)
  );

endmodule

// File: tb/tb_operand_collector.sv
// Scoreboard bench for operand_collector: directed issues push expected EXE
// results; a negedge monitor pops and compares on every out handshake.
module tb_operand_collector;
  import opcol_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  operand_collector_if bus ();

  reg_addr_t   rf_raddr1, rf_raddr2, id_dest;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        rf_rdata1_valid, rf_rdata2_valid;
  logic        flush, timeout;
  logic [7:0]  stall_cycles;

  logic [31:0] rf_data [32];
  logic        rf_vld  [32];

  assign rf_rdata1       = rf_data[rf_raddr1];
  assign rf_rdata2       = rf_data[rf_raddr2];
  assign rf_rdata1_valid = rf_vld[rf_raddr1];
  assign rf_rdata2_valid = rf_vld[rf_raddr2];

  operand_collector dut (
    .clk             (clk),
    .resetn          (resetn),
    .bus             (bus),
    .rf_raddr1       (rf_raddr1),
    .rf_raddr2       (rf_raddr2),
    .rf_rdata1       (rf_rdata1),
    .rf_rdata2       (rf_rdata2),
    .rf_rdata1_valid (rf_rdata1_valid),
    .rf_rdata2_valid (rf_rdata2_valid),
    .id_dest         (id_dest),
    .flush           (flush),
    .stall_cycles    (stall_cycles),
    .timeout         (timeout)
  );

  typedef struct {
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  dest;
    logic [31:0] pc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         id_cnt = 0;
  logic [4:0] id_last = '0;
  int         to_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (id_dest != '0) begin
        id_cnt++;
        id_last = id_dest;
      end
      if (timeout) to_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_issue: got dest 0x%0h, expected no issue", bus.out_dest);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_rs_data", bus.out_rs_data, mon_e.rs);
          check("sb_rt_data", bus.out_rt_data, mon_e.rt);
          check("sb_dest", {27'd0, bus.out_dest}, {27'd0, mon_e.dest});
          check("sb_pc", bus.out_pc, mon_e.pc);
        end
      end
    end
  end

  function automatic exp_t mk(input logic [31:0] rs, rt, input logic [4:0] dest,
                              input logic [31:0] pc);
    exp_t e;
    e.rs = rs; e.rt = rt; e.dest = dest; e.pc = pc;
    return e;
  endfunction

  // Returns #1 after the accept edge.
  task automatic issue(input reg_addr_t rs, rt, dest, input logic urs, urt,
                       input logic [31:0] pc);
    int n;
    @(posedge clk); #1;
    bus.in_rs = rs; bus.in_rt = rt; bus.in_dest = dest;
    bus.in_use_rs = urs; bus.in_use_rt = urt; bus.in_pc = pc;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 50) check("accept_wait_expired", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_data[i] = 32'h100 + i;
      rf_vld[i]  = 1'b1;
    end
    rf_data[0] = 32'hFFFF_FFFF;
    rf_data[3] = 32'h11;
    rf_data[4] = 32'h22;
    rf_data[5] = 32'hDEAD;
    rf_data[6] = 32'h66;
    bus.in_valid = 1'b0; bus.in_rs = '0; bus.in_rt = '0; bus.in_dest = '0;
    bus.in_use_rs = 1'b0; bus.in_use_rt = 1'b0; bus.in_pc = 32'd0;
    bus.out_ready = 1'b1;
    flush = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_id_dest", id_dest, 0);
    check("rst_stall", stall_cycles, 0);
    check("rst_timeout", timeout, 0);
    check("rst_raddr1", rf_raddr1, 0);
    resetn = 1'b1;

    // ready operands: minimum latency
    exp_q.push_back(mk(32'h11, 32'h22, 5'd7, 32'h100));
    issue(5'd3, 5'd4, 5'd7, 1'b1, 1'b1, 32'h100);
    @(negedge clk);
    check("t1_wait_out_valid", bus.out_valid, 0);
    check("t1_wait_in_ready", bus.in_ready, 0);
    check("t1_raddr1", rf_raddr1, 3);
    check("t1_raddr2", rf_raddr2, 4);
    @(negedge clk);
    check("t1_out_valid", bus.out_valid, 1);
    check("t1_id_dest", id_dest, 7);
    check("t1_stall", stall_cycles, 0);
    @(negedge clk);
    check("t1_id_dest_clear", id_dest, 0);
    check("t1_retired", bus.out_valid, 0);
    check("t1_idle_ready", bus.in_ready, 1);

    // rs not valid for six WAIT cycles
    @(posedge clk); #1;
    id_cnt = 0;
    rf_vld[5] = 1'b0;
    exp_q.push_back(mk(32'hDEAD, 32'h22, 5'd9, 32'h200));
    issue(5'd5, 5'd4, 5'd9, 1'b1, 1'b1, 32'h200);
    repeat (6) @(posedge clk);
    #1 rf_vld[5] = 1'b1;
    @(negedge clk);
    check("t2_stall_in_wait", stall_cycles, 6);
    check("t2_no_valid_yet", bus.out_valid, 0);
    @(negedge clk);
    check("t2_out_valid", bus.out_valid, 1);
    check("t2_id_dest", id_dest, 9);
    repeat (3) @(negedge clk);
    check("t2_stall_hold", stall_cycles, 6);
    check("t2_id_pulses", id_cnt, 1);
    check("t2_id_last", id_last, 9);

    // rs=0 is always ready and reads as zero
    rf_vld[0] = 1'b0;
    exp_q.push_back(mk(32'h0, 32'h22, 5'd2, 32'h300));
    issue(5'd0, 5'd4, 5'd2, 1'b1, 1'b1, 32'h300);
    @(negedge clk);
    check("t3_stall_cleared", stall_cycles, 0);
    @(negedge clk);
    check("t3_out_valid", bus.out_valid, 1);
    check("t3_stall", stall_cycles, 0);

    // HOLD backpressure then back-to-back retire/accept
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    exp_q.push_back(mk(32'h11, 32'h22, 5'd10, 32'h400));
    issue(5'd3, 5'd4, 5'd10, 1'b1, 1'b1, 32'h400);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("t4_hold_valid", bus.out_valid, 1);
      check("t4_hold_rs", bus.out_rs_data, 32'h11);
      check("t4_hold_dest", bus.out_dest, 10);
      check("t4_hold_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.in_rs = 5'd4; bus.in_rt = 5'd3; bus.in_dest = 5'd11;
    bus.in_use_rs = 1'b1; bus.in_use_rt = 1'b1; bus.in_pc = 32'h500;
    bus.in_valid = 1'b1;
    exp_q.push_back(mk(32'h22, 32'h11, 5'd11, 32'h500));
    @(negedge clk);
    check("t4_b2b_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t4_b2b_out_valid", bus.out_valid, 0);
    check("t4_b2b_wait", bus.in_ready, 0);
    check("t4_b2b_raddr1", rf_raddr1, 4);
    @(negedge clk);
    check("t4_b2b_issue", bus.out_valid, 1);

    // flush in WAIT
    @(posedge clk); #1;
    id_cnt = 0;
    rf_vld[5] = 1'b0;
    issue(5'd5, 5'd4, 5'd12, 1'b1, 1'b1, 32'h600);
    @(negedge clk);
    check("t5_wait", bus.in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    rf_vld[5] = 1'b1;
    @(negedge clk);
    check("t5_flush_idle", bus.in_ready, 1);
    check("t5_flush_stall", stall_cycles, 0);
    repeat (3) @(negedge clk);
    check("t5_flush_no_issue", bus.out_valid, 0);
    check("t5_flush_no_id", id_cnt, 0);

    // flush in HOLD concurrent with a new instruction
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    id_cnt = 0;
    issue(5'd3, 5'd4, 5'd13, 1'b1, 1'b1, 32'h700);
    repeat (2) @(negedge clk);
    check("t5h_hold", bus.out_valid, 1);
    @(posedge clk); #1;
    flush = 1'b1;
    bus.in_rs = 5'd4; bus.in_rt = 5'd3; bus.in_dest = 5'd14; bus.in_pc = 32'h800;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("t5h_no_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t5h_out_valid", bus.out_valid, 0);
    check("t5h_idle", bus.in_ready, 1);
    repeat (3) @(negedge clk);
    check("t5h_not_accepted", bus.out_valid, 0);
    check("t5h_id_pulses", id_cnt, 1);

    // reset mid-WAIT
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    id_cnt = 0;
    rf_vld[5] = 1'b0;
    issue(5'd5, 5'd4, 5'd16, 1'b1, 1'b1, 32'hA00);
    @(negedge clk); #2;
    resetn = 1'b0;
    #1;
    check("t6_async_rst_ready", bus.in_ready, 1);
    check("t6_async_rst_stall", stall_cycles, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    rf_vld[5] = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_no_issue", bus.out_valid, 0);
    check("t6_no_id", id_cnt, 0);

    // operand never valid
    @(posedge clk); #1;
    rf_vld[6] = 1'b0;
    to_cnt = 0;
    issue(5'd3, 5'd6, 5'd15, 1'b1, 1'b1, 32'h900);
`ifdef OPCOL_WATCHDOG_EN
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!timeout && n < 300) begin
        @(negedge clk);
        n++;
      end
      check("t7_timeout_seen", timeout, 1);
      check("t7_timeout_stall", stall_cycles, 255);
      check("t7_timeout_idle", bus.in_ready, 1);
      @(negedge clk);
      check("t7_timeout_pulse", timeout, 0);
      check("t7_timeout_count", to_cnt, 1);
      check("t7_no_issue", bus.out_valid, 0);
    end
`else
    repeat (300) @(negedge clk);
    check("t7_stall_sat", stall_cycles, 255);
    check("t7_no_timeout", to_cnt, 0);
    check("t7_still_wait", bus.in_ready, 0);
    check("t7_no_issue", bus.out_valid, 0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("t7_flush_idle", bus.in_ready, 1);
    check("t7_flush_stall", stall_cycles, 0);
`endif

    repeat (2) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
